// File: rtl/reg_context_sequencer.sv
// Register-bank context sequencer: streams regs FIRST_REG..LAST_REG
// to data memory (save) or back from it (restore) while the CPU stalls.
module reg_context_sequencer #(
  parameter int unsigned FIRST_REG = 1,
  parameter int unsigned LAST_REG  = 31,
  parameter int unsigned ADDR_STEP = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_save,
  input  logic        start_restore,
  input  logic [31:0] base_addr,
  output logic        busy,
  output logic        done,
  output logic [4:0]  reg_rs_addr,
  input  logic [31:0] reg_rs_data,
  output logic [4:0]  reg_rd_addr,
  output logic        reg_write,
  output logic [31:0] reg_wdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SAVE   = 3'd1;
  localparam logic [2:0] S_RLOAD  = 3'd2;
  localparam logic [2:0] S_RWRITE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [4:0] LP_FIRST = 5'(FIRST_REG);
  localparam logic [4:0] LP_LAST  = 5'(LAST_REG);

  logic [2:0]  r_state;
  logic [4:0]  r_idx;
  logic [31:0] r_base;
  logic [31:0] r_data;

  logic        w_last;
  logic        w_save;
  logic        w_rload;
  logic        w_rwrite;
  logic [31:0] w_off;

  assign w_last   = (r_idx == LP_LAST);
  assign w_save   = (r_state == S_SAVE);
  assign w_rload  = (r_state == S_RLOAD);
  assign w_rwrite = (r_state == S_RWRITE);
  assign w_off    = 32'(r_idx - LP_FIRST) * 32'(ADDR_STEP);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= LP_FIRST;
      r_base  <= '0;
      r_data  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start_save) begin
            r_base  <= base_addr;
            r_idx   <= LP_FIRST;
            r_state <= S_SAVE;
          end else if (start_restore) begin
            r_base  <= base_addr;
            r_idx   <= LP_FIRST;
            r_state <= S_RLOAD;
          end
        end
        S_SAVE: begin
          if (mem_ready) begin
            if (w_last) r_state <= S_DONE;
            else        r_idx   <= r_idx + 5'd1;
          end
        end
        S_RLOAD: begin
          if (mem_ready) begin
            r_data  <= mem_rdata;
            r_state <= S_RWRITE;
          end
        end
        S_RWRITE: begin
          if (w_last) begin
            r_state <= S_DONE;
          end else begin
            r_idx   <= r_idx + 5'd1;
            r_state <= S_RLOAD;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode from state only, so reset clears them at once
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign mem_we      = w_save;
  assign mem_re      = w_rload;
  assign reg_write   = w_rwrite;
  assign reg_rs_addr = w_save ? r_idx : 5'd0;
  assign reg_rd_addr = w_rwrite ? r_idx : 5'd0;
  assign reg_wdata   = w_rwrite ? r_data : 32'd0;
  assign mem_wdata   = w_save ? reg_rs_data : 32'd0;
  assign mem_addr    = (w_save | w_rload) ? (r_base + w_off) : 32'd0;

endmodule

// File: tb/tb_reg_context_sequencer.sv
// Bench for reg_context_sequencer: bank/memory model, write logs and a
// spec-level model of final images, latency and ordering.
module tb_reg_context_sequencer;

  localparam int N = 31;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start_save = 1'b0;
  logic        start_restore = 1'b0;
  logic [31:0] base_addr = '0;
  logic        busy, done;
  logic [4:0]  reg_rs_addr, reg_rd_addr;
  logic [31:0] reg_rs_data, reg_wdata;
  logic        reg_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re;
  logic        mem_ready = 1'b0;

  always #5 clock = ~clock;

  reg_context_sequencer dut (
    .clock(clock), .reset(reset),
    .start_save(start_save), .start_restore(start_restore),
    .base_addr(base_addr), .busy(busy), .done(done),
    .reg_rs_addr(reg_rs_addr), .reg_rs_data(reg_rs_data),
    .reg_rd_addr(reg_rd_addr), .reg_write(reg_write),
    .reg_wdata(reg_wdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  logic [31:0] regs [32];
  logic [31:0] mem [1024];
  logic [31:0] ld_regs [32];
  logic [31:0] ld_mem [1024];
  logic        ld_go = 1'b0;
  logic [31:0] m_regs [32];
  logic [31:0] m_mem [1024];

  logic [31:0] wr_a_q [$];
  logic [31:0] wr_d_q [$];
  logic [4:0]  rw_i_q [$];
  logic [31:0] rw_d_q [$];
  int          both_cnt = 0;

  int total = 0;
  int bad = 0;

  assign reg_rs_data = regs[reg_rs_addr];
  assign mem_rdata   = mem[mem_addr[9:0]];

  // Register bank and memory that the sequencer talks to
  always @(posedge clock) begin
    if (ld_go) begin
      regs <= ld_regs;
      mem  <= ld_mem;
    end else begin
      if (mem_we && mem_ready) begin
        mem[mem_addr[9:0]] <= mem_wdata;
        wr_a_q.push_back(mem_addr);
        wr_d_q.push_back(mem_wdata);
      end
      if (reg_write) begin
        regs[reg_rd_addr] <= reg_wdata;
        rw_i_q.push_back(reg_rd_addr);
        rw_d_q.push_back(reg_wdata);
      end
    end
    if (mem_we && mem_re) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic load_bank();
    @(negedge clock);
    ld_go = 1'b1;
    @(negedge clock);
    ld_go = 1'b0;
    m_regs = ld_regs;
    m_mem  = ld_mem;
  endtask

  task automatic rand_image();
    ld_regs[0] = '0;
    for (int k = 1; k < 32; k++) ld_regs[k] = $urandom;
    for (int i = 0; i < 1024; i++) ld_mem[i] = $urandom;
  endtask

  task automatic run_op(input bit save, input logic [31:0] base,
                        input int pct, input int stall_at,
                        input bit both, input bit mid);
    int q0 = wr_a_q.size();
    int r0 = rw_i_q.size();
    int c = 0;
    int stalls = 0;
    int held = 0;
    int busy_bad = 0;
    int hold_bad = 0;
    int nexp;
    bit seen = 0;
    bit st_prev = 0;
    logic [31:0] pa = '0, pd = '0, a;
    logic [4:0]  prs = '0;
    @(negedge clock);
    start_save    = save | both;
    start_restore = !save | both;
    base_addr     = base;
    mem_ready     = 1'b1;
    while (!seen && c < 400) begin
      @(negedge clock);
      c++;
      start_save    = 1'b0;
      start_restore = mid && (c == 10);
      base_addr     = $urandom;
      if (!busy) busy_bad++;
      if (st_prev && (mem_addr != pa || mem_wdata != pd ||
                      reg_rs_addr != prs)) hold_bad++;
      if (done) begin
        seen = 1;
        mem_ready = 1'b1;
      end else begin
        mem_ready = ($urandom_range(99) < pct);
        if (mem_we && stall_at != 0 && reg_rs_addr == 5'(stall_at)
            && held < 3) begin
          mem_ready = 1'b0;
          held++;
        end
        st_prev = (mem_we || mem_re) && !mem_ready;
        if (st_prev) stalls++;
        pa = mem_addr; pd = mem_wdata; prs = reg_rs_addr;
      end
    end
    start_restore = 1'b0;
    nexp = (save || both) ? N + stalls + 1 : 2 * N + stalls + 1;
    chk("done_seen", 32'(seen), 1);
    chk("latency", c, nexp);
    chk("busy_run", busy_bad, 0);
    chk("addr_hold", hold_bad, 0);
    @(negedge clock);
    chk("idle_after", {30'd0, busy, done}, 0);
    repeat (3) @(negedge clock);
    chk("no_queue", {31'd0, busy}, 0);
    if (save || both) begin
      chk("save_nwr", wr_a_q.size() - q0, N);
      chk("save_nrw", rw_i_q.size() - r0, 0);
      for (int k = 1; k <= N && q0 + k - 1 < wr_a_q.size(); k++) begin
        a = base + 32'(k - 1);
        chk("save_addr", wr_a_q[q0 + k - 1], a);
        chk("save_data", wr_d_q[q0 + k - 1], m_regs[k]);
      end
      for (int k = 1; k <= N; k++) begin
        a = base + 32'(k - 1);
        m_mem[a[9:0]] = m_regs[k];
        chk("mem_img", mem[a[9:0]], m_mem[a[9:0]]);
      end
    end else begin
      chk("rst_nwr", wr_a_q.size() - q0, 0);
      chk("rst_nrw", rw_i_q.size() - r0, N);
      for (int k = 1; k <= N && r0 + k - 1 < rw_i_q.size(); k++) begin
        a = base + 32'(k - 1);
        chk("rst_idx", 32'(rw_i_q[r0 + k - 1]), k);
        chk("rst_data", rw_d_q[r0 + k - 1], m_mem[a[9:0]]);
      end
      for (int k = 1; k <= N; k++) begin
        a = base + 32'(k - 1);
        m_regs[k] = m_mem[a[9:0]];
        chk("reg_img", regs[k], m_regs[k]);
      end
    end
  endtask

  initial begin
    int c;
    int r0;
    bit dn;
    logic [31:0] a;
    @(negedge clock);
    chk("reset_ctl", {27'd0, busy, done, mem_we, mem_re, reg_write}, 0);
    chk("reset_addr", mem_addr, 0);
    chk("reset_wd", mem_wdata | reg_wdata, 0);
    reset = 1'b0;

    // Save of k*0x11 to 0x100
    rand_image();
    for (int k = 1; k < 32; k++) ld_regs[k] = 32'(k * 'h11);
    load_bank();
    run_op(1, 32'h100, 100, 0, 0, 0);

    // Restore from 0x200 holding 0xA000+i
    for (int i = 0; i < N; i++) ld_mem[10'h200 + 10'(i)] = 32'hA000 + 32'(i);
    ld_regs = m_regs;
    load_bank();
    run_op(0, 32'h200, 100, 0, 0, 0);
    chk("reg31", regs[31], 32'hA01E);

    run_op(1, 32'h300, 100, 5, 0, 0);
    run_op(1, 32'h140, 100, 0, 1, 1);
    chk("never_both", both_cnt, 0);

    for (int t = 0; t < 6; t++)
      run_op(($urandom_range(1) == 1), $urandom, 60, 0, 0, 0);

    // Reset while restoring, after the 10th register is written
    rand_image();
    load_bank();
    r0 = rw_i_q.size();
    @(negedge clock);
    start_restore = 1'b1;
    base_addr = 32'h200;
    mem_ready = 1'b1;
    @(negedge clock);
    start_restore = 1'b0;
    c = 0;
    while (rw_i_q.size() - r0 < 10 && c < 100) begin
      @(negedge clock);
      c++;
    end
    chk("mid_wait", rw_i_q.size() - r0, 10);
    reset = 1'b1;
    #1;
    chk("mid_rst_ctl", {27'd0, busy, done, mem_we, mem_re, reg_write}, 0);
    chk("mid_rst_addr", mem_addr, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    dn = 0;
    repeat (5) begin
      @(negedge clock);
      if (done || busy) dn = 1;
    end
    chk("mid_no_done", 32'(dn), 0);
    chk("mid_nrw", rw_i_q.size() - r0, 10);
    for (int k = 1; k <= 10; k++) begin
      a = 32'h200 + 32'(k - 1);
      m_regs[k] = m_mem[a[9:0]];
    end
    for (int k = 1; k <= N; k++) chk("mid_regs", regs[k], m_regs[k]);
    run_op(1, 32'h180, 100, 0, 0, 0);

    // Address wraps 0xFFFFFFFF -> 0 at reg 17
    run_op(1, 32'hFFFF_FFF0, 100, 0, 0, 0);
    chk("never_both", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
